// File: rtl/flag_progress_anim.sv
// Animated Progress Pride flag pixel generator.
// Produces the chevron/rainbow colour of the current pixel one cycle after the
// coordinates are presented. Chevrons can wipe in from the left, and the
// rainbow field can scroll vertically, both paced by frame_start strobes.
//
// Ports:
//   clk          pixel clock
//   rst_n        asynchronous active-low reset
//   pix_x        current pixel column
//   pix_y        current pixel row
//   frame_start  one-cycle pulse per frame, paces the animation
//   go           one-cycle start pulse; samples mode
//   mode         0 static, 1 wipe-in, 2 scroll, 3 treated as static
//   color        registered pixel colour, RRGGBB
//   busy         high while a wipe is in progress
//   done         high once a wipe has completed; cleared by go or reset
module flag_progress_anim #(
   parameter int unsigned V_ACTIVE   = 480,
   parameter int unsigned CHEVRON_W  = 60,
   parameter int unsigned N_CHEVRONS = 5,
   parameter int unsigned APEX       = 180,
   parameter int unsigned STEP       = 4,
   parameter int unsigned SPEED_DIV  = 1
) (
   input  logic       clk,
   input  logic       rst_n,
   input  logic [9:0] pix_x,
   input  logic [9:0] pix_y,
   input  logic       frame_start,
   input  logic       go,
   input  logic [1:0] mode,
   output logic [5:0] color,
   output logic       busy,
   output logic       done
);

   localparam int unsigned CW = 6;
   localparam int unsigned PW = 10;
   localparam int unsigned AW = 16;
   localparam int unsigned DW = 8;

   localparam int unsigned STRIPE_H   = V_ACTIVE / 6;
   localparam int          SLIDE_RAW  = int'(V_ACTIVE / 2 + N_CHEVRONS * CHEVRON_W) - int'(APEX);
   localparam int          SLIDE_INIT = (SLIDE_RAW > 0) ? SLIDE_RAW : 0;

   localparam logic [CW-1:0] WHITE  = 6'h3F;
   localparam logic [CW-1:0] PINK   = 6'h3B;
   localparam logic [CW-1:0] LTBLUE = 6'h1F;
   localparam logic [CW-1:0] BROWN  = 6'h24;
   localparam logic [CW-1:0] BLACK  = 6'h00;
   localparam logic [CW-1:0] RED    = 6'h30;
   localparam logic [CW-1:0] ORANGE = 6'h34;
   localparam logic [CW-1:0] YELLOW = 6'h3C;
   localparam logic [CW-1:0] GREEN  = 6'h0C;
   localparam logic [CW-1:0] BLUE   = 6'h03;
   localparam logic [CW-1:0] PURPLE = 6'h22;

   typedef enum logic [1:0] {
      S_IDLE   = 2'd0,
      S_WIPE   = 2'd1,
      S_HOLD   = 2'd2,
      S_SCROLL = 2'd3
   } state_t;

   state_t        state_q, state_d;
   logic [AW-1:0] slide_q, slide_d;
   logic [AW-1:0] scroll_q, scroll_d;
   logic [DW-1:0] div_q, div_d;
   logic          busy_d, done_d;
   logic [CW-1:0] color_d;
   logic          advance_c;
   logic [AW-1:0] scroll_sum_c;

   logic signed [AW-1:0] y_c;
   logic signed [AW-1:0] tri_y_c;
   logic signed [AW-1:0] x_eff_c;
   logic        [AW-1:0] row_c;

   function automatic logic [CW-1:0] chevron_color(input int idx);
      case (idx)
         0:       chevron_color = WHITE;
         1:       chevron_color = PINK;
         2:       chevron_color = LTBLUE;
         3:       chevron_color = BROWN;
         default: chevron_color = BLACK;
      endcase
   endfunction

   // Pixel colour: folded chevron test first, rainbow stripe otherwise
   always_comb begin
      y_c     = AW'(pix_y);
      tri_y_c = (pix_y < PW'(V_ACTIVE / 2)) ? y_c : (AW'(V_ACTIVE - 1) - y_c);
      x_eff_c = AW'(pix_x) + slide_q;

      // Single conditional subtract is enough: pix_y and scroll are both below V_ACTIVE
      row_c = AW'(pix_y) + scroll_q;
      if (row_c >= AW'(V_ACTIVE)) begin
         row_c = row_c - AW'(V_ACTIVE);
      end

      if      (row_c < AW'(1 * STRIPE_H)) color_d = RED;
      else if (row_c < AW'(2 * STRIPE_H)) color_d = ORANGE;
      else if (row_c < AW'(3 * STRIPE_H)) color_d = YELLOW;
      else if (row_c < AW'(4 * STRIPE_H)) color_d = GREEN;
      else if (row_c < AW'(5 * STRIPE_H)) color_d = BLUE;
      else                                color_d = PURPLE;

      // Walk outermost to innermost so the lowest matching band is applied last
      for (int i = int'(N_CHEVRONS) - 1; i >= 0; i--) begin
         if (x_eff_c < (tri_y_c + AW'((i + 1) * int'(CHEVRON_W) - int'(APEX)))) begin
            color_d = chevron_color(i);
         end
      end
   end

   // Next-state logic: go restarts from any state, otherwise frame pacing
   always_comb begin
      state_d      = state_q;
      slide_d      = slide_q;
      scroll_d     = scroll_q;
      div_d        = div_q;
      busy_d       = busy;
      done_d       = done;
      advance_c    = 1'b0;
      scroll_sum_c = scroll_q + AW'(STEP);

      if (go) begin
         div_d  = '0;
         done_d = 1'b0;
         case (mode)
            2'd1: begin
               state_d  = S_WIPE;
               slide_d  = AW'(SLIDE_INIT);
               scroll_d = '0;
               busy_d   = 1'b1;
            end
            2'd2: begin
               state_d  = S_SCROLL;
               slide_d  = '0;
               scroll_d = '0;
               busy_d   = 1'b0;
            end
            default: begin
               state_d  = S_IDLE;
               slide_d  = '0;
               scroll_d = '0;
               busy_d   = 1'b0;
            end
         endcase
      end else begin
         case (state_q)
            S_IDLE: begin
               div_d    = '0;
               slide_d  = '0;
               scroll_d = '0;
            end
            S_HOLD: begin
               div_d   = '0;
               slide_d = '0;
            end
            S_WIPE, S_SCROLL: begin
               if (frame_start) begin
                  if (div_q >= DW'(SPEED_DIV - 1)) begin
                     div_d     = '0;
                     advance_c = 1'b1;
                  end else begin
                     div_d = div_q + DW'(1);
                  end
               end
               if (advance_c && (state_q == S_WIPE)) begin
                  if (slide_q <= AW'(STEP)) begin
                     slide_d = '0;
                     state_d = S_HOLD;
                     busy_d  = 1'b0;
                     done_d  = 1'b1;
                  end else begin
                     slide_d = slide_q - AW'(STEP);
                  end
               end
               if (advance_c && (state_q == S_SCROLL)) begin
                  scroll_d = (scroll_sum_c >= AW'(V_ACTIVE)) ? (scroll_sum_c - AW'(V_ACTIVE))
                                                              : scroll_sum_c;
               end
            end
            default: begin
               state_d = S_IDLE;
            end
         endcase
      end
   end

   // State and output registers
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q  <= S_IDLE;
         slide_q  <= '0;
         scroll_q <= '0;
         div_q    <= '0;
         busy     <= 1'b0;
         done     <= 1'b0;
         color    <= '0;
      end else begin
         state_q  <= state_d;
         slide_q  <= slide_d;
         scroll_q <= scroll_d;
         div_q    <= div_d;
         busy     <= busy_d;
         done     <= done_d;
         color    <= color_d;
      end
   end

endmodule

// File: tb/tb_flag_progress_anim.sv
// Bench for flag_progress_anim: two instances (advance every frame and every
// third frame) share stimulus and are compared every cycle against a
// behavioural flag model, plus directed checks of known pixels.
module tb_flag_progress_anim;

   localparam int V_ACTIVE   = 480;
   localparam int CHEVRON_W  = 60;
   localparam int N_CHEVRONS = 5;
   localparam int APEX       = 180;
   localparam int STEP       = 60;

   localparam int PH_IDLE   = 0;
   localparam int PH_WIPE   = 1;
   localparam int PH_HOLD   = 2;
   localparam int PH_SCROLL = 3;

   logic       clk;
   logic       rst_n;
   logic [9:0] pix_x;
   logic [9:0] pix_y;
   logic       frame_start;
   logic       go;
   logic [1:0] mode;
   logic [5:0] color_a, color_b;
   logic       busy_a, busy_b;
   logic       done_a, done_b;

   int n_tests;
   int n_fail;

   // Reference model state, index 0 = instance a, 1 = instance b
   int m_ph     [2];
   int m_slide  [2];
   int m_scroll [2];
   int m_frames [2];
   bit m_busy   [2];
   bit m_done   [2];
   int m_div    [2];
   logic [5:0] exp_color [2];

   flag_progress_anim #(
      .V_ACTIVE(480), .CHEVRON_W(60), .N_CHEVRONS(5), .APEX(180), .STEP(60), .SPEED_DIV(1)
   ) u_dut_a (
      .clk(clk), .rst_n(rst_n), .pix_x(pix_x), .pix_y(pix_y),
      .frame_start(frame_start), .go(go), .mode(mode),
      .color(color_a), .busy(busy_a), .done(done_a)
   );

   flag_progress_anim #(
      .V_ACTIVE(480), .CHEVRON_W(60), .N_CHEVRONS(5), .APEX(180), .STEP(60), .SPEED_DIV(3)
   ) u_dut_b (
      .clk(clk), .rst_n(rst_n), .pix_x(pix_x), .pix_y(pix_y),
      .frame_start(frame_start), .go(go), .mode(mode),
      .color(color_b), .busy(busy_b), .done(done_b)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_tests++;
      if (got !== exp) begin
         n_fail++;
         $display("FAIL %s got=%0h exp=%0h at %0t", tag, got, exp, $time);
      end
   endtask

   function automatic logic [5:0] chev_pal(input int i);
      case (i)
         0: return 6'h3F;
         1: return 6'h3B;
         2: return 6'h1F;
         3: return 6'h24;
         default: return 6'h00;
      endcase
   endfunction

   function automatic logic [5:0] rainbow_pal(input int s);
      case (s)
         0: return 6'h30;
         1: return 6'h34;
         2: return 6'h3C;
         3: return 6'h0C;
         4: return 6'h03;
         default: return 6'h22;
      endcase
   endfunction

   function automatic logic [5:0] ref_color(input int x, input int y, input int sl, input int sc);
      int tri_y;
      int xe;
      tri_y = (y < V_ACTIVE / 2) ? y : V_ACTIVE - 1 - y;
      xe = x + sl;
      for (int i = 0; i < N_CHEVRONS; i++) begin
         if (xe < tri_y + (i + 1) * CHEVRON_W - APEX) return chev_pal(i);
      end
      return rainbow_pal(((y + sc) % V_ACTIVE) / (V_ACTIVE / 6));
   endfunction

   function automatic int speed_of(input int k);
      return (k == 0) ? 1 : 3;
   endfunction

   task automatic ref_reset();
      for (int k = 0; k < 2; k++) begin
         m_ph[k] = PH_IDLE; m_slide[k] = 0; m_scroll[k] = 0;
         m_busy[k] = 0; m_done[k] = 0; m_div[k] = 0; m_frames[k] = 0;
      end
   endtask

   // One clock edge of the flag animation for instance k
   task automatic ref_step(input int k, input bit g, input int m, input bit fs);
      if (g) begin
         m_div[k] = 0;
         m_done[k] = 0;
         m_slide[k] = 0;
         m_scroll[k] = 0;
         m_busy[k] = 0;
         if (m == 1) begin
            m_ph[k] = PH_WIPE;
            m_slide[k] = V_ACTIVE / 2 + N_CHEVRONS * CHEVRON_W - APEX;
            m_busy[k] = 1;
         end else if (m == 2) begin
            m_ph[k] = PH_SCROLL;
         end else begin
            m_ph[k] = PH_IDLE;
         end
      end else if (fs && (m_ph[k] == PH_WIPE || m_ph[k] == PH_SCROLL)) begin
         m_div[k]++;
         if (m_div[k] == speed_of(k)) begin
            m_div[k] = 0;
            if (m_ph[k] == PH_WIPE) begin
               m_slide[k] = (m_slide[k] > STEP) ? m_slide[k] - STEP : 0;
               if (m_slide[k] == 0) begin
                  m_ph[k] = PH_HOLD;
                  m_busy[k] = 0;
                  m_done[k] = 1;
               end
            end else begin
               m_scroll[k] = (m_scroll[k] + STEP) % V_ACTIVE;
            end
         end
      end
   endtask

   // Drive one cycle of inputs, advance the model at the edge, compare after it
   task automatic cycle(input int x, input int y, input bit g, input int m, input bit fs);
      @(negedge clk);
      pix_x = 10'(x);
      pix_y = 10'(y);
      go = g;
      mode = 2'(m);
      frame_start = fs;
      @(posedge clk);
      for (int k = 0; k < 2; k++) begin
         exp_color[k] = ref_color(x, y, m_slide[k], m_scroll[k]);
         ref_step(k, g, m, fs);
      end
      #1;
      check("color_a", 32'(color_a), 32'(exp_color[0]));
      check("busy_a",  32'(busy_a),  32'(m_busy[0]));
      check("done_a",  32'(done_a),  32'(m_done[0]));
      check("color_b", 32'(color_b), 32'(exp_color[1]));
      check("busy_b",  32'(busy_b),  32'(m_busy[1]));
      check("done_b",  32'(done_b),  32'(m_done[1]));
   endtask

   task automatic hold_pix(input int x, input int y);
      cycle(x, y, 0, 0, 0);
      cycle(x, y, 0, 0, 0);
   endtask

   initial begin
      n_tests = 0;
      n_fail = 0;
      rst_n = 1'b0;
      pix_x = '0; pix_y = '0; frame_start = 1'b0; go = 1'b0; mode = '0;
      ref_reset();
      #1;
      check("reset_color", 32'(color_a), 32'h0);
      check("reset_busy",  32'(busy_a),  32'h0);
      check("reset_done",  32'(done_a),  32'h0);
      #20;
      @(negedge clk);
      rst_n = 1'b1;

      // Static geometry
      hold_pix(0, 0);     check("static_0_0",     32'(color_a), 32'h24);
      hold_pix(0, 240);   check("static_0_240",   32'(color_a), 32'h3F);
      hold_pix(639, 0);   check("static_639_0",   32'(color_a), 32'h30);
      hold_pix(639, 479); check("static_639_479", 32'(color_a), 32'h22);
      hold_pix(100, 0);   check("static_100_0",   32'(color_a), 32'h00);

      // Wipe-in
      cycle(0, 240, 1, 1, 0);
      check("wipe_busy", 32'(busy_a), 32'h1);
      cycle(0, 240, 0, 0, 0);
      check("wipe_start_green", 32'(color_a), 32'h0C);
      for (int p = 0; p < 6; p++) begin
         cycle(0, 240, 0, 0, 1);
         cycle(0, 240, 0, 0, 0);
      end
      check("wipe_end_busy", 32'(busy_a), 32'h0);
      check("wipe_end_done", 32'(done_a), 32'h1);
      check("wipe_end_white", 32'(color_a), 32'h3F);
      check("wipe_slow_busy", 32'(busy_b), 32'h1);
      for (int p = 0; p < 14; p++) cycle(0, 240, 0, 0, 1);
      cycle(30, 200, 1, 1, 1);
      cycle(30, 200, 0, 0, 1);
      cycle(30, 200, 0, 0, 1);
      hold_pix(30, 200);

      // Scroll
      cycle(639, 0, 1, 2, 0);
      for (int a = 1; a <= 8; a++) begin
         cycle(639, 0, 0, 0, 1);
         cycle(639, 0, 0, 0, 0);
         if (a == 1) check("scroll_1_red",    32'(color_a), 32'h30);
         if (a == 2) check("scroll_2_orange", 32'(color_a), 32'h34);
         if (a == 8) check("scroll_8_wrap",   32'(color_a), 32'h30);
      end

      // Reserved mode restarts to static
      cycle(639, 0, 0, 0, 1);
      cycle(639, 0, 1, 3, 0);
      cycle(639, 0, 0, 0, 0);
      check("restart_red",  32'(color_a), 32'h30);
      check("restart_done", 32'(done_a),  32'h0);

      // Reset mid-wipe
      cycle(0, 240, 1, 1, 0);
      cycle(0, 240, 0, 0, 1);
      cycle(0, 240, 0, 0, 1);
      @(negedge clk);
      rst_n = 1'b0;
      #1;
      check("midreset_color", 32'(color_a), 32'h0);
      check("midreset_busy",  32'(busy_a),  32'h0);
      check("midreset_done",  32'(done_a),  32'h0);
      check("midreset_busy_b", 32'(busy_b), 32'h0);
      ref_reset();
      @(negedge clk);
      @(negedge clk);
      rst_n = 1'b1;
      hold_pix(0, 240);
      check("postreset_white", 32'(color_a), 32'h3F);

      // Randomised traffic against the model
      for (int n = 0; n < 3000; n++) begin
         cycle(int'($urandom_range(639, 0)), int'($urandom_range(479, 0)),
               ($urandom_range(39, 0) == 0), int'($urandom_range(3, 0)),
               ($urandom_range(3, 0) == 0));
      end

      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end

endmodule

// File: doc/flag_progress_anim.md
Name: flag_progress_anim

Overview:
Parametrised, animated Progress Pride flag generator for the VGA pride-flag mux. It computes the chevron/rainbow colour for the current pixel with a configurable chevron count, width and apex. Chevrons can wipe in from the left edge, and the rainbow field can scroll vertically, paced by frame strobes. The output colour is registered: 6-bit RRGGBB, 2 bits per channel.

Parameters:
V_ACTIVE, 480, visible lines. Must be a multiple of 12.
CHEVRON_W, 60, horizontal width of each chevron band in pixels.
N_CHEVRONS, 5, number of chevron bands, 1..5.
APEX, 180, horizontal pull-back of the chevron stack in pixels.
STEP, 4, pixels moved per animation advance, 1..V_ACTIVE-1.
SPEED_DIV, 1, frame_start pulses per animation advance, 1..255.

Ports:
clk  in  1  pixel clock.
rst_n  in  1  reset, asynchronous, active-low.
pix_x  in  10  current pixel column.
pix_y  in  10  current pixel row.
frame_start  in  1  one-cycle pulse once per frame.
go  in  1  one-cycle start pulse; samples mode.
mode  in  2  animation mode: 0 static, 1 wipe-in, 2 scroll, 3 reserved (treated as static).
color  out  6  registered pixel colour.
busy  out  1  high while a wipe is in progress.
done  out  1  high once a wipe has completed; cleared by go or reset.

Behaviour:
- Palette:
  - WHITE=6'h3F, PINK=6'h3B, LTBLUE=6'h1F, BROWN=6'h24, BLACK=6'h00.
  - Rainbow, top to bottom: RED=6'h30, ORANGE=6'h34, YELLOW=6'h3C, GREEN=6'h0C, BLUE=6'h03, PURPLE=6'h22.
- Fold: tri_y = (pix_y < V_ACTIVE/2) ? pix_y : V_ACTIVE-1-pix_y.
- Chevron geometry:
  - x_eff = pix_x + slide. Use signed arithmetic of at least 12 bits, no truncation.
  - Chevron i (0 = innermost) spans x_eff < tri_y + (i+1)*CHEVRON_W - APEX.
  - The lowest matching i wins, with colour palette[i] in order WHITE, PINK, LTBLUE, BROWN, BLACK.
  - If no chevron matches, the pixel is rainbow.
- Rainbow: row = (pix_y + scroll) mod V_ACTIVE; stripe = row / (V_ACTIVE/6). Implement with comparators, not a divider.
- Latency: color reflects the pix_x/pix_y of the previous clock edge, i.e. exactly 1 cycle. slide and scroll are sampled in the same cycle as pix_x/pix_y.
- FSM states: IDLE, WIPE, HOLD, SCROLL.
  - IDLE: slide=0, scroll=0.
  - go with mode=1 → WIPE: slide = V_ACTIVE/2 + N_CHEVRONS*CHEVRON_W - APEX, busy=1, done=0.
  - go with mode=2 → SCROLL: scroll=0.
  - go with mode=0 or 3 → IDLE: slide=0, scroll=0, done=0.
  - go in any state restarts per the rule above, and clears the divider.
- Advance: the divider counts frame_start pulses. On reaching SPEED_DIV-1 together with a frame_start, it emits an advance and returns to 0. In IDLE and HOLD the divider is held at 0.
- WIPE on advance:
  - slide = max(slide-STEP, 0).
  - When slide reaches 0: → HOLD, busy=0, done=1.
- HOLD: static image, slide=0; remains until go.
- SCROLL on advance: scroll = scroll+STEP; if the result ≥ V_ACTIVE, subtract V_ACTIVE (wrap). Chevrons stay static.
- Simultaneous events: go and frame_start in the same cycle → go wins; no advance that cycle.
- Reset values (async, immediate on rst_n low): color=0, busy=0, done=0, state=IDLE, slide=0, scroll=0, divider=0. Outputs stay at these values until the first clock edge after release.
- mode is ignored except on cycles where go=1.

Test Plan:
- Static geometry, defaults, no go, each pixel held ≥2 cycles:
  - (0,0) → BROWN 6'h24.
  - (0,240) → WHITE 6'h3F.
  - (639,0) → RED 6'h30.
  - (639,479) → PURPLE 6'h22.
  - (100,0) → PINK? No: x=100, tri=0, 100 ≥ 120-... → BLACK 6'h00 requires 100<120 → BLACK 6'h00.
- Wipe, STEP=60, SPEED_DIV=1:
  - go, mode=1 → slide=360, busy=1; (0,240) → GREEN 6'h0C.
  - After 6 frame_start pulses → busy=0, done=1; (0,240) → WHITE.
- Wipe pacing, SPEED_DIV=3: slide drops by 60 only on every 3rd frame_start. go coincident with frame_start → no advance that cycle.
- Scroll, STEP=60, pixel (639,0):
  - After 1 advance → RED; after 2 → ORANGE 6'h34.
  - After 8 → scroll wraps 420→0 → RED; scroll never reads ≥480.
- Reset mid-wipe: rst_n low after 2 advances → color=0, busy=0, done=0 immediately with no clock. After release, (0,240) → WHITE.
- Restart/reserved: go with mode=3 during SCROLL → IDLE, scroll=0; (639,0) → RED; done stays 0.
